// File: rtl/my_pkg.sv
// Shared types for the RV32M/RV64M multiply/divide unit.
// Opcodes, FSM states and opcode classification helpers.
package my_pkg;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } op_type;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } muldiv_state_t;

    function automatic logic is_div_op(op_type op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(op_type op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(op_type op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(op_type op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative XLEN-wide multiply/divide unit, one bit per cycle.
// Multiplier and divider share one 2*XLEN shift register and counter.
module mul_div_unit
    import my_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  op_type          i,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int W2 = 2 * XLEN;

    muldiv_state_t   state_q, state_d;
    op_type          op_q, op_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // Decode operand signs and magnitudes for a new request
    always_comb begin
        sign_a = op_signed_a(i) & opA[XLEN-1];
        sign_b = op_signed_b(i) & opB[XLEN-1];
        mag_a  = sign_a ? -opA : opA;
        mag_b  = sign_b ? -opB : opB;
        accept = start && (state_q == IDLE || state_q == DONE);
    end

    // Shift-add / restoring-divide step and final sign correction
    always_comb begin
        add_sum = {1'b0, acc_q[W2-1:XLEN]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = acc_q[W2-1:XLEN-1];
        trial   = rem_sh - {1'b0, opb_q};
        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = neg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    end

    // Next-state logic; kill overrides everything and freezes result
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d  = i;
                    neg_d = is_rem_op(i) ? sign_a : (sign_a ^ sign_b);
                    opb_d = mag_b;
                    if (is_div_op(i) && opB == '0) begin
                        state_d  = DONE;
                        result_d = is_rem_op(i) ? opA : '1;
                    end else begin
                        state_d = ITER;
                        cnt_d   = CW'(XLEN - 1);
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (is_div_op(op_q)) begin
                    acc_d = trial[XLEN]
                          ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {add_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                unique case (op_q)
                    OP_MUL:    result_d = acc_q[XLEN-1:0];
                    OP_MULH:   result_d = prod[W2-1:XLEN];
                    OP_MULHSU: result_d = prod[W2-1:XLEN];
                    OP_MULHU:  result_d = prod[W2-1:XLEN];
                    OP_DIV:    result_d = quo;
                    OP_DIVU:   result_d = quo;
                    OP_REM:    result_d = rem;
                    OP_REMU:   result_d = rem;
                endcase
                state_d = DONE;
            end
        endcase
        if (kill) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ITER) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus random checks of mul_div_unit at XLEN=32.
// Expected results go through a scoreboard queue.
module tb_mul_div_unit;
    import my_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            kill;
    op_type          i;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] sb[$];

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .kill   (kill),
        .i      (i),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] model(op_type op, logic [31:0] a,
                                         logic [31:0] b);
        logic [63:0] sa, sb2, ua, ub, p;
        logic signed [63:0] xa, xb;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        xa  = $signed(sa);
        xb  = $signed(sb2);
        p   = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;  return p[31:0];  end
            OP_MULH:   begin p = sa * sb2; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub;  return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;  return p[63:32]; end
            OP_DIV:  begin
                if (b == 0) return '1;
                p = xa / xb;
                return p[31:0];
            end
            OP_DIVU: return (b == 0) ? '1 : a / b;
            OP_REM:  begin
                if (b == 0) return a;
                p = xa % xb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive start now (caller is at a negedge); returns at next negedge
    task automatic issue_now(input op_type op, input logic [31:0] a,
                             input logic [31:0] b,
                             input logic [31:0] exp);
        i     = op;
        opA   = a;
        opB   = b;
        start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input op_type op, input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge clk);
        issue_now(op, a, b, exp);
    endtask

    // Wait for done, checking latency, busy count and result
    task automatic collect(input string tag, input int lat,
                           input int cyc0);
        int cyc;
        int nb;
        logic [31:0] exp;
        cyc = cyc0;
        nb  = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy cycles"}, 64'(nb), 64'(lat - cyc0));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, " result"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int seen;
        op_type rop;
        logic [31:0] ra, rb;
        reset_n = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;
        i       = OP_MUL;
        opA     = '0;
        opB     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        reset_n = 1'b1;

        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        collect("mul", LAT, 1);
        @(negedge clk);
        check("done pulse", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        check("result held", 64'(result), 64'hFFFFFFEB);

        issue(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
        collect("mulh", LAT, 1);
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        collect("mulhu", LAT, 1);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collect("mulhsu", LAT, 1);

        issue(OP_DIVU, 32'd7, 32'd2, 32'd3);
        collect("divu", LAT, 1);
        issue(OP_REMU, 32'd7, 32'd2, 32'd1);
        collect("remu", LAT, 1);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        collect("div", LAT, 1);
        issue(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        collect("rem", LAT, 1);

        @(negedge clk);
        i     = OP_DIV;
        opA   = 32'd100;
        opB   = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("kill pre busy", 64'(busy), 64'(1));
        kill  = 1'b1;
        start = 1'b1;
        i     = OP_MUL;
        opA   = 32'd2;
        opB   = 32'd2;
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        check("kill busy", 64'(busy), 64'(0));
        check("kill done", 64'(done), 64'(0));
        check("kill result", 64'(result), 64'hFFFFFFFF);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("kill quiet", 64'(seen), 64'(0));

        issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
        collect("divu by 0", 1, 1);
        issue(OP_REM, 32'd5, 32'd0, 32'd5);
        collect("rem by 0", 1, 1);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        collect("div ovf", LAT, 1);
        issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        collect("rem ovf", LAT, 1);

        issue(OP_MUL, 32'd3, 32'd5, 32'd15);
        start = 1'b1;
        i     = OP_DIVU;
        opA   = 32'd100;
        opB   = 32'd7;
        repeat (10) @(negedge clk);
        start = 1'b0;
        collect("start held", LAT, 11);

        issue(OP_DIVU, 32'd7, 32'd2, 32'd3);
        collect("b2b first", LAT, 1);
        issue_now(OP_REMU, 32'd7, 32'd2, 32'd1);
        collect("b2b second", LAT, 1);

        @(negedge clk);
        i     = OP_MUL;
        opA   = 32'd9;
        opB   = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst result", 64'(result), 64'(0));
        issue(OP_MUL, 32'd6, 32'd7, 32'd42);
        collect("after rst", LAT, 1);

        for (int k = 0; k < 8; k++) begin
            rop = op_type'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (k == 0) ? 32'd0 : $urandom;
            if (k == 1) rb = rb >> 20;
            issue(rop, ra, rb, model(rop, ra, rb));
            collect("random",
                    (rop >= OP_DIV && rb == 0) ? 1 : LAT, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
